// File: rtl/armleocpu_store_unit_if.sv
// AW/W/B write-channel bundle (AXI4-Lite subset) between the store unit and the data bus.
interface armleocpu_store_unit_if #(
  parameter int ADDR_WIDTH = 34
);
  logic                  m_awvalid;
  logic                  m_awready;
  logic [ADDR_WIDTH-1:0] m_awaddr;
  logic                  m_wvalid;
  logic                  m_wready;
  logic [31:0]           m_wdata;
  logic [3:0]            m_wstrb;
  logic                  m_bvalid;
  logic                  m_bready;
  logic [1:0]            m_bresp;

  modport master (
    output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    input  m_awready, m_wready, m_bvalid, m_bresp
  );

  modport slave (
    input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    output m_awready, m_wready, m_bvalid, m_bresp
  );
endinterface

// File: rtl/armleocpu_store_unit.sv
// Single-outstanding store sequencer: execute-stage request -> AW/W/B write channels.
// Optional saturating store/error counters when ARMLEOCPU_STORE_UNIT_STATS_EN is defined.
module armleocpu_store_unit #(
  parameter int ADDR_WIDTH = 34
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_type,
  input  logic [31:0]           req_data,
  output logic                  resp_valid,
  output logic [1:0]            resp_status,
  output logic                  busy,
`ifdef ARMLEOCPU_STORE_UNIT_STATS_EN
  output logic [31:0]           stat_store_count,
  output logic [15:0]           stat_error_count,
`endif
  armleocpu_store_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_B = 2'd2
  } state_t;

  localparam logic [1:0] ST_OK         = 2'd0;
  localparam logic [1:0] ST_MISALIGNED = 2'd1;
  localparam logic [1:0] ST_UNKNOWN    = 2'd2;
  localparam logic [1:0] ST_BUS_ERROR  = 2'd3;

  state_t                state_q, state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [1:0]            resp_status_q, resp_status_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  misaligned;

  assign misaligned = ((req_type == 2'd2) && (req_addr[1:0] != 2'b00)) ||
                      ((req_type == 2'd1) && req_addr[0]);

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_status = resp_status_q;

  assign bus.m_awvalid = awvalid_q;
  assign bus.m_awaddr  = awaddr_q;
  assign bus.m_wvalid  = wvalid_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.m_wstrb   = wstrb_q;
  assign bus.m_bready  = bready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= 2'd0;
      awaddr_q      <= '0;
      wdata_q       <= 32'd0;
      wstrb_q       <= 4'd0;
    end else begin
      state_q       <= state_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      resp_valid_q  <= resp_valid_d;
      resp_status_q <= resp_status_d;
      awaddr_q      <= awaddr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    resp_valid_d  = 1'b0;
    resp_status_d = resp_status_q;
    awaddr_d      = awaddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          // Unknown type wins over misalignment; both complete without touching the bus.
          if (req_type == 2'd3) begin
            resp_valid_d  = 1'b1;
            resp_status_d = ST_UNKNOWN;
          end else if (misaligned) begin
            resp_valid_d  = 1'b1;
            resp_status_d = ST_MISALIGNED;
          end else begin
            state_d   = ISSUE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            wdata_d   = req_data << {req_addr[1:0], 3'b000};
            case (req_type)
              2'd0:    wstrb_d = 4'b0001 << req_addr[1:0];
              2'd1:    wstrb_d = 4'b0011 << req_addr[1:0];
              default: wstrb_d = 4'b1111;
            endcase
          end
        end
      end

      ISSUE: begin
        // AW and W retire independently; move on only once both have handshaken.
        awvalid_d = awvalid_q && !bus.m_awready;
        wvalid_d  = wvalid_q && !bus.m_wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WAIT_B;
          bready_d = 1'b1;
        end
      end

      WAIT_B: begin
        if (bus.m_bvalid && bready_q) begin
          state_d       = IDLE;
          bready_d      = 1'b0;
          resp_valid_d  = 1'b1;
          resp_status_d = bus.m_bresp[1] ? ST_BUS_ERROR : ST_OK;
        end
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef ARMLEOCPU_STORE_UNIT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_store_count <= 32'd0;
      stat_error_count <= 16'd0;
    end else if (resp_valid_q) begin
      if (resp_status_q == ST_OK) begin
        if (stat_store_count != 32'hFFFF_FFFF) stat_store_count <= stat_store_count + 32'd1;
      end else begin
        if (stat_error_count != 16'hFFFF) stat_error_count <= stat_error_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_armleocpu_store_unit.sv
// Directed self-checking bench for armleocpu_store_unit; inputs change and outputs are sampled on the falling edge.
module tb_armleocpu_store_unit;
  localparam int AW = 34;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_type;
  logic [31:0]   req_data;
  logic          resp_valid;
  logic [1:0]    resp_status;
  logic          busy;
`ifdef ARMLEOCPU_STORE_UNIT_STATS_EN
  logic [31:0]   stat_store_count;
  logic [15:0]   stat_error_count;
`endif

  int checks = 0;
  int errors = 0;

  armleocpu_store_unit_if #(.ADDR_WIDTH(AW)) bus ();

  armleocpu_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_type    (req_type),
    .req_data    (req_data),
    .resp_valid  (resp_valid),
    .resp_status (resp_status),
    .busy        (busy),
`ifdef ARMLEOCPU_STORE_UNIT_STATS_EN
    .stat_store_count (stat_store_count),
    .stat_error_count (stat_error_count),
`endif
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  task automatic set_req(input logic [AW-1:0] a, input logic [1:0] t, input logic [31:0] d);
    req_valid = 1'b1;
    req_addr  = a;
    req_type  = t;
    req_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_type = 2'd0; req_data = 32'd0;
    bus.m_awready = 1'b1; bus.m_wready = 1'b1; bus.m_bvalid = 1'b0; bus.m_bresp = 2'b00;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({bus.m_awvalid, bus.m_wvalid, bus.m_bready} !== 3'b000) begin errors++; $display("FAIL reset_bus_valids: got %b expected 000", {bus.m_awvalid, bus.m_wvalid, bus.m_bready}); end
    checks++; if ({bus.m_awaddr, bus.m_wdata, bus.m_wstrb, resp_status} !== '0) begin errors++; $display("FAIL reset_payload: got %h/%h/%h/%h expected zeros", bus.m_awaddr, bus.m_wdata, bus.m_wstrb, resp_status); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word();
    bus.m_awready = 1'b1; bus.m_wready = 1'b1; bus.m_bvalid = 1'b1; bus.m_bresp = 2'b00;
    set_req(34'h1000, 2'd2, 32'hDEADBEEF);
    @(negedge clk); req_valid = 1'b0;
    checks++; if ({bus.m_awvalid, bus.m_wvalid} !== 2'b11) begin errors++; $display("FAIL word_valids: got %b expected 11", {bus.m_awvalid, bus.m_wvalid}); end
    checks++; if (bus.m_awaddr !== 34'h1000) begin errors++; $display("FAIL word_awaddr: got %h expected 1000", bus.m_awaddr); end
    checks++; if (bus.m_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL word_wdata: got %h expected deadbeef", bus.m_wdata); end
    checks++; if (bus.m_wstrb !== 4'b1111) begin errors++; $display("FAIL word_wstrb: got %b expected 1111", bus.m_wstrb); end
    checks++; if ({req_ready, busy} !== 2'b01) begin errors++; $display("FAIL word_issue_ready_busy: got %b expected 01", {req_ready, busy}); end
    @(negedge clk);
    checks++; if ({bus.m_awvalid, bus.m_wvalid, bus.m_bready, resp_valid} !== 4'b0010) begin errors++; $display("FAIL word_waitb: got %b expected 0010", {bus.m_awvalid, bus.m_wvalid, bus.m_bready, resp_valid}); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL word_waitb_ready: got %b expected 0", req_ready); end
    @(negedge clk);
    checks++; if ({resp_valid, resp_status} !== 3'b1_00) begin errors++; $display("FAIL word_resp: got %b/%0d expected 1/0", resp_valid, resp_status); end
    checks++; if ({bus.m_bready, req_ready} !== 2'b01) begin errors++; $display("FAIL word_done_bready_ready: got %b expected 01", {bus.m_bready, req_ready}); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL word_resp_pulse: got %b expected 0", resp_valid); end
  endtask

  task automatic test_lanes();
    logic [AW-1:0] a  [2] = '{34'h2003, 34'h2002};
    logic [1:0]    t  [2] = '{2'd0, 2'd1};
    logic [31:0]   d  [2] = '{32'h000000A5, 32'h00001234};
    logic [31:0]   ew [2] = '{32'hA5000000, 32'h12340000};
    logic [3:0]    es [2] = '{4'b1000, 4'b1100};
    bus.m_awready = 1'b1; bus.m_wready = 1'b1; bus.m_bvalid = 1'b1; bus.m_bresp = 2'b00;
    for (int i = 0; i < 2; i++) begin
      set_req(a[i], t[i], d[i]);
      @(negedge clk); req_valid = 1'b0;
      checks++; if (bus.m_awaddr !== 34'h2000) begin errors++; $display("FAIL lane%0d_awaddr: got %h expected 2000", i, bus.m_awaddr); end
      checks++; if (bus.m_wdata !== ew[i]) begin errors++; $display("FAIL lane%0d_wdata: got %h expected %h", i, bus.m_wdata, ew[i]); end
      checks++; if (bus.m_wstrb !== es[i]) begin errors++; $display("FAIL lane%0d_wstrb: got %b expected %b", i, bus.m_wstrb, es[i]); end
      repeat (2) @(negedge clk);
      checks++; if ({resp_valid, resp_status} !== 3'b1_00) begin errors++; $display("FAIL lane%0d_resp: got %b/%0d expected 1/0", i, resp_valid, resp_status); end
    end
    @(negedge clk);
  endtask

  task automatic test_errors();
    logic [AW-1:0] a  [3] = '{34'h2001, 34'h2002, 34'h2001};
    logic [1:0]    t  [3] = '{2'd1, 2'd2, 2'd3};
    logic [1:0]    es [3] = '{2'd1, 2'd1, 2'd2};
    for (int i = 0; i < 3; i++) begin
      set_req(a[i], t[i], 32'h55AA55AA);
      @(negedge clk); req_valid = 1'b0;
      checks++; if ({resp_valid, resp_status} !== {1'b1, es[i]}) begin errors++; $display("FAIL err%0d_resp: got %b/%0d expected 1/%0d", i, resp_valid, resp_status, es[i]); end
      checks++; if ({bus.m_awvalid, bus.m_wvalid, req_ready, busy} !== 4'b0010) begin errors++; $display("FAIL err%0d_nobus: got %b expected 0010", i, {bus.m_awvalid, bus.m_wvalid, req_ready, busy}); end
    end
    @(negedge clk);
  endtask

  task automatic test_skew();
    bus.m_awready = 1'b0; bus.m_wready = 1'b1; bus.m_bvalid = 1'b1; bus.m_bresp = 2'b10;
    set_req(34'h3004, 2'd2, 32'hCAFEF00D);
    @(negedge clk); req_valid = 1'b0;
    checks++; if ({bus.m_awvalid, bus.m_wvalid} !== 2'b11) begin errors++; $display("FAIL skew_start: got %b expected 11", {bus.m_awvalid, bus.m_wvalid}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({bus.m_awvalid, bus.m_wvalid, bus.m_bready} !== 3'b100) begin errors++; $display("FAIL skew_hold%0d: got %b expected 100", i, {bus.m_awvalid, bus.m_wvalid, bus.m_bready}); end
      checks++; if (bus.m_awaddr !== 34'h3004) begin errors++; $display("FAIL skew_addr%0d: got %h expected 3004", i, bus.m_awaddr); end
    end
    bus.m_awready = 1'b1;
    @(negedge clk);
    checks++; if ({bus.m_awvalid, bus.m_bready} !== 2'b01) begin errors++; $display("FAIL skew_bready: got %b expected 01", {bus.m_awvalid, bus.m_bready}); end
    @(negedge clk);
    checks++; if ({resp_valid, resp_status} !== 3'b1_11) begin errors++; $display("FAIL skew_buserr: got %b/%0d expected 1/3", resp_valid, resp_status); end
    bus.m_bresp = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bus.m_awready = 1'b1; bus.m_wready = 1'b1; bus.m_bvalid = 1'b1; bus.m_bresp = 2'b00;
    set_req(34'h4000, 2'd2, 32'h11111111);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low%0d: got %b expected 0", i, req_ready); end
    end
    @(negedge clk);
    checks++; if ({resp_valid, req_ready} !== 2'b11) begin errors++; $display("FAIL b2b_first_resp: got %b expected 11", {resp_valid, req_ready}); end
    set_req(34'h4008, 2'd0, 32'h00000077);
    @(negedge clk); req_valid = 1'b0;
    checks++; if ({resp_valid, bus.m_awvalid} !== 2'b01) begin errors++; $display("FAIL b2b_second_accept: got %b expected 01", {resp_valid, bus.m_awvalid}); end
    checks++; if ({bus.m_awaddr, bus.m_wstrb} !== {34'h4008, 4'b0001}) begin errors++; $display("FAIL b2b_second_payload: got %h/%b expected 4008/0001", bus.m_awaddr, bus.m_wstrb); end
    repeat (2) @(negedge clk);
    checks++; if ({resp_valid, resp_status} !== 3'b1_00) begin errors++; $display("FAIL b2b_second_resp: got %b/%0d expected 1/0", resp_valid, resp_status); end
    @(negedge clk);
  endtask

  task automatic test_rst_midop();
    bus.m_awready = 1'b1; bus.m_wready = 1'b1; bus.m_bvalid = 1'b0; bus.m_bresp = 2'b00;
    set_req(34'h5000, 2'd2, 32'hA5A5A5A5);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    checks++; if ({bus.m_bready, busy} !== 2'b11) begin errors++; $display("FAIL rst_in_waitb: got %b expected 11", {bus.m_bready, busy}); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({bus.m_awvalid, bus.m_wvalid, bus.m_bready, resp_valid, req_ready, busy} !== 6'b000010) begin errors++; $display("FAIL rst_midop_state: got %b expected 000010", {bus.m_awvalid, bus.m_wvalid, bus.m_bready, resp_valid, req_ready, busy}); end
    checks++; if (bus.m_awaddr !== '0) begin errors++; $display("FAIL rst_midop_awaddr: got %h expected 0", bus.m_awaddr); end
`ifdef ARMLEOCPU_STORE_UNIT_STATS_EN
    checks++; if ({stat_store_count, stat_error_count} !== 48'd0) begin errors++; $display("FAIL rst_stats: got %0d/%0d expected 0/0", stat_store_count, stat_error_count); end
`endif
    bus.m_bvalid = 1'b1;
    @(negedge clk);
    checks++; if ({resp_valid, bus.m_bready} !== 2'b00) begin errors++; $display("FAIL rst_no_resp: got %b expected 00", {resp_valid, bus.m_bready}); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_skew();
    test_back_to_back();
    test_rst_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/armleocpu_store_unit.md
Name: armleocpu_store_unit

Overview:
- Sequences single-outstanding stores from the execute stage onto the data-bus write channels (AW/W/B, AXI4-Lite subset).
- Per request: rejects misaligned and unknown-type stores locally; otherwise shifts data into byte lanes and builds the byte strobe; issues address and data; waits for the write response; reports a status back to the pipeline.
- Sits between the execute stage and the data-cache/bus port; owns the only path by which stores reach memory.

Parameters:
ADDR_WIDTH, 34, byte-address width of req_addr and m_awaddr (covers Sv32 physical addresses).

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  store request valid
req_ready  output  1  unit can accept a request
req_addr  input  ADDR_WIDTH  byte address of store
req_type  input  2  0=byte, 1=half, 2=word, 3=unknown
req_data  input  32  store data, right-aligned (LSB-justified)
resp_valid  output  1  one-cycle completion pulse
resp_status  output  2  0=OK, 1=misaligned, 2=unknown type, 3=bus error
busy  output  1  request in flight (state != IDLE)
m_awvalid  output  1  write address valid
m_awready  input  1  write address ready
m_awaddr  output  ADDR_WIDTH  word-aligned address {req_addr[ADDR_WIDTH-1:2],2'b00}
m_wvalid  output  1  write data valid
m_wready  input  1  write data ready
m_wdata  output  32  lane-aligned data = req_data << (8*req_addr[1:0])
m_wstrb  output  4  byte strobe
m_bvalid  input  1  write response valid
m_bready  output  1  write response ready
m_bresp  input  2  write response code

Behaviour:
- Reset values: state=IDLE; req_ready=1; resp_valid, m_awvalid, m_wvalid, m_bready, busy = 0; resp_status, m_awaddr, m_wdata, m_wstrb = 0.
- States: IDLE, ISSUE, WAIT_B.
- req_ready = (state==IDLE). A request is accepted on req_valid && req_ready.

Accept in IDLE, error check:
- Misaligned: word with addr[1:0]!=0, or half with addr[0]=1.
- Unknown: type==3. Unknown takes priority over misaligned.
- On error: no bus activity. resp_valid=1 next cycle with status 2 or 1; state stays IDLE.

Accept in IDLE, legal request:
- Register m_awaddr, m_wdata and m_wstrb.
- m_wstrb: word=4'b1111; half=4'b0011<<addr[1:0]; byte=4'b0001<<addr[1:0]. Shift results truncated to 4 and 32 bits.
- Next cycle: state=ISSUE, m_awvalid=m_wvalid=1.

ISSUE:
- Each valid drops the cycle after its own handshake; the two handshakes are independent and may complete in either order or in the same cycle.
- AW/W payloads stay stable while the corresponding valid is high.
- Once both handshakes are done, state=WAIT_B and m_bready=1 in the following cycle.

WAIT_B:
- On m_bvalid && m_bready, next cycle: m_bready=0, state=IDLE, resp_valid=1.
- resp_status = 0 if m_bresp[1]==0 (OKAY/EXOKAY), else 3.

Timing and ordering:
- resp_valid has no back-pressure. It may coincide with req_ready=1, and a new request may be accepted in that same cycle.
- Minimum legal-store latency with ready slaves: accept at T, AW/W handshake at T+1, bready at T+2, B at T+2, resp_valid at T+3.
- m_bvalid arriving before WAIT_B is ignored, since m_bready=0.

Reset and invariants:
- rst mid-operation forces the reset values at the next edge, regardless of state. An outstanding bus transaction is abandoned; the bus is reset alongside.
- No state other than IDLE asserts req_ready.

Optional Feature:
- Macro: ARMLEOCPU_STORE_UNIT_STATS_EN.
- When defined, adds two outputs, both reset to 0 and saturating at all-ones:
  - stat_store_count[31:0]: increments on every resp_valid with status 0.
  - stat_error_count[15:0]: increments on every resp_valid with status !=0.
- When undefined, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Word store: addr=0x1000, type=2, data=0xDEADBEEF, slaves always ready, bresp=0 -> m_awaddr=0x1000, m_wdata=0xDEADBEEF, m_wstrb=4'b1111, resp_valid at T+3 with status 0.
- Byte store: addr=0x2003, type=0, data=0x000000A5 -> m_awaddr=0x2000, m_wdata=0xA5000000, m_wstrb=4'b1000.
- Half store: addr=0x2002, data=0x1234 -> m_wdata=0x12340000, m_wstrb=4'b1100. Half addr=0x2001 -> no m_awvalid, resp_status=1 next cycle. Word addr=0x2002 -> status 1. Type=3 at addr=0x2001 -> status 2.
- Skewed handshakes: m_awready held low 3 cycles while m_wready=1 -> m_wvalid drops after 1 cycle, m_awvalid held with stable addr, m_bready asserted only after AW completes; bresp=2'b10 -> status 3.
- Back-to-back: second req_valid held high -> accepted in the resp_valid cycle of the first; ready stays low throughout ISSUE/WAIT_B.
- rst asserted in WAIT_B -> next cycle all valids/bready 0, req_ready=1, no resp_valid. With STATS_EN defined, counters read 0.
